hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the decoder's MULT, DIV, MTHL and MFHL one-hot pairs plus the rs/rt operands.
- Runs MULT/MULTU over a fixed pipelined latency and DIV/DIVU with an iterative radix-2 divider.
- Raises a stall to the pipeline while busy and serves MFHI/MFLO reads.

Parameters:
- MUL_STAGES, 2, cycles from accept to HI/LO update for multiply (≥1).
- DIV_ITERS, 32, radix-2 divide iterations (fixed by the 32-bit datapath).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- op_valid  in  1  EX instruction valid and allowed to proceed.
- mult  in  2  [1]=MULTU, [0]=MULT.
- div  in  2  [1]=DIVU, [0]=DIV.
- mthl  in  2  [1]=MTHI, [0]=MTLO.
- mfhl  in  2  [1]=MFHI, [0]=MFLO.
- src_a  in  32  rs value (dividend / multiplicand / MT data).
- src_b  in  32  rt value (divisor / multiplier).
- cancel  in  1  exception/eret flush; aborts in-flight op.
- busy  out  1  operation in flight.
- stall  out  1  hold EX stage this cycle.
- done  out  1  one-cycle pulse in the cycle HI/LO is written by mul/div.
- mf_data  out  32  mfhl[1] ? HI : LO.
- hi_out, lo_out  out  32 each  current HI/LO.

Behaviour:
- Reset (resetn low, async): state IDLE, HI=LO=0, busy=0, done=0, counter=0.
- States: IDLE, MUL, DIV, FIX.
  - Accept in IDLE when op_valid & ~cancel & (mult|div) != 0; T denotes the accept cycle.
  - Priority if the decoder violates one-hot: div > mult > mthl.
- MUL:
  - Product is 64-bit, signed (33-bit sign extension) for MULT, zero-extended for MULTU.
  - busy high T+1..T+MUL_STAGES; HI=prod[63:32], LO=prod[31:0] at the edge ending T+MUL_STAGES; done high in T+MUL_STAGES.
- DIV:
  - Restoring divide on magnitudes (|src| for DIV, raw for DIVU), DIV_ITERS cycles T+1..T+32, then FIX in T+33.
  - FIX: quotient negated if signs differ (DIV only); remainder takes dividend sign.
  - LO=quotient, HI=remainder at the edge ending T+33; done high in T+33.
  - Divisor zero is not trapped: magnitude quotient 0xFFFFFFFF, remainder = |dividend|, then normal sign fix.
- MTHI/MTLO: accepted in IDLE when op_valid & ~cancel; writes src_a at the end of the accept cycle; no busy.
- mf_data: combinational from the HI/LO registers.
- stall = op_valid & busy & (mult|div|mthl|mfhl != 0). Non-HI/LO instructions never stall.
- cancel:
  - Any busy state returns to IDLE next edge with no HI/LO write and no done.
  - In IDLE, cancel blocks acceptance and MT writes.
- Back-to-back: a new op is acceptable in the cycle after done (state IDLE).
- Operands are latched at accept; src_a/src_b are ignored afterward.

Optional Feature:
- HILO_FWD_EN defined:
  - In the done cycle, stall is not raised for pure MFHI/MFLO.
  - mf_data returns the value being written (result forward); mul/div/mt in that cycle still stall.
- Undefined: stall holds through the done cycle; mf_data is register-only.

Decomposition:
- muldiv_pkg holds:
  - State encoding (IDLE/MUL/DIV/FIX).
  - DIV_ITERS constant.
  - Bit positions for the mult/div/mthl/mfhl pairs (HI=1, LO=0; unsigned=1, signed=0).
- One sub-module, div_iter_core: restoring divider taking magnitudes, start, cancel; returns quotient/remainder after DIV_ITERS cycles.
- Multiplier pipeline and sign fix stay in the top.

Test Plan:
- MULT src_a=0xFFFFFFFE(-2), src_b=3 -> after MUL_STAGES, HI=0xFFFFFFFF, LO=0xFFFFFFFA, done one pulse; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at T+33; busy high exactly 33 cycles; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- DIV issued, MFLO presented at T+5 -> stall high until the done cycle (or one cycle earlier with HILO_FWD_EN), mf_data equals the new LO.
- cancel asserted at T+10 of a DIV -> busy low at T+11, HI/LO unchanged, no done; a MULT accepted next cycle completes normally.
- MTHI 0x12345678 then MFHI next cycle -> mf_data=0x12345678, no stall; MTLO with cancel -> LO unchanged.
- resetn pulled low mid-DIV -> immediately busy=0, HI=LO=0, state IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  // Bit positions inside the decoder's one-hot pairs.
  localparam int HL_HI = 1;
  localparam int HL_LO = 0;
  localparam int OP_U  = 1;
  localparam int OP_S  = 0;

  // Sign corrections applied to the magnitude divider result.
  typedef struct packed {
    logic q_neg;
    logic r_neg;
  } div_sign_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per cycle.
module div_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic                 active;
  logic [DIV_CNT_W-1:0] cnt;
  logic [31:0]          quo_q;
  logic [31:0]          rem_q;
  logic [31:0]          dvs_q;
  logic [32:0]          rem_sh;
  logic [32:0]          diff;
  logic                 ge;

  // A zero divisor always subtracts, giving an all-ones quotient and remainder = dividend.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = (rem_sh >= {1'b0, dvs_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      cnt    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (cancel) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (active) begin
      quo_q <= {quo_q[30:0], ge};
      rem_q <= ge ? diff[31:0] : rem_sh[31:0];
      cnt   <= cnt + DIV_CNT_W'(1);
      if (last) active <= 1'b0;
    end
  end

  assign last      = active & (cnt == DIV_CNT_W'(DIV_ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Optional HILO_FWD_EN: forwards the result to MFHI/MFLO in the done cycle.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  mult,
  input  logic [1:0]  div,
  input  logic [1:0]  mthl,
  input  logic [1:0]  mfhl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] mf_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MCNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  logic [1:0]        state;
  logic [MCNT_W-1:0] mcnt;
  logic [31:0]       hi_q, lo_q;
  logic [32:0]       mul_a, mul_b;
  logic [63:0]       prod_now, prod_q, mul_res;
  div_sign_t         sgn;
  logic              idle_ok, accept_div, accept_mul, mt_wr;
  logic              a_neg, b_neg, mul_last, core_last;
  logic [31:0]       quo, rem, res_hi, res_lo, mf_reg;
  logic              hl_any;

  assign idle_ok    = (state == S_IDLE) & op_valid & ~cancel;
  assign accept_div = idle_ok & (|div);
  assign accept_mul = idle_ok & ~(|div) & (|mult);
  assign mt_wr      = idle_ok & ~(|div) & ~(|mult) & (|mthl);

  assign a_neg = div[OP_S] & src_a[31];
  assign b_neg = div[OP_S] & src_b[31];

  div_iter_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept_div),
    .cancel    (cancel),
    .dividend  (neg_if(src_a, a_neg)),
    .divisor   (neg_if(src_b, b_neg)),
    .last      (core_last),
    .quotient  (quo),
    .remainder (rem)
  );

  // Low 64 bits of the product of the 33-bit extended operands equal the signed/unsigned result.
  assign prod_now = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
  assign mul_res  = (MUL_STAGES == 1) ? prod_now : prod_q;
  assign mul_last = (state == S_MUL) & (mcnt == MCNT_W'(MUL_STAGES - 1));
  assign done     = ~cancel & (mul_last | (state == S_FIX));
  assign busy     = (state != S_IDLE);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    res_hi = mul_res[63:32];
    res_lo = mul_res[31:0];
    if (state == S_FIX) begin
      res_hi = neg_if(rem, sgn.r_neg);
      res_lo = neg_if(quo, sgn.q_neg);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      mcnt   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      prod_q <= '0;
      sgn    <= '0;
    end else begin
      if (mt_wr) begin
        if (mthl[HL_HI]) hi_q <= src_a;
        if (mthl[HL_LO]) lo_q <= src_a;
      end
      if (done) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (state == S_MUL) prod_q <= prod_now;

      case (state)
        S_IDLE: begin
          if (accept_div) begin
            state <= S_DIV;
            sgn   <= '{q_neg: a_neg ^ b_neg, r_neg: a_neg};
          end else if (accept_mul) begin
            state <= S_MUL;
            mcnt  <= '0;
            mul_a <= {mult[OP_S] & src_a[31], src_a};
            mul_b <= {mult[OP_S] & src_b[31], src_b};
          end
        end
        S_MUL: begin
          if (cancel || mul_last) begin
            state <= S_IDLE;
            mcnt  <= '0;
          end else begin
            mcnt <= mcnt + MCNT_W'(1);
          end
        end
        S_DIV: begin
          if (cancel)         state <= S_IDLE;
          else if (core_last) state <= S_FIX;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hl_any = |{mult, div, mthl, mfhl};
  assign mf_reg = mfhl[HL_HI] ? hi_q : lo_q;

`ifdef HILO_FWD_EN
  logic pure_mf;
  assign pure_mf = (|mfhl) & ~(|{mult, div, mthl});
  assign stall   = op_valid & busy & hl_any & ~(done & pure_mf);
  assign mf_data = done ? (mfhl[HL_HI] ? res_hi : res_lo) : mf_reg;
`else
  assign stall   = op_valid & busy & hl_any;
  assign mf_data = mf_reg;
`endif

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
